// File: rtl/mux_sel_scan.sv
// Registered N:1 word multiplexer. It has a direct-select mode and an auto-scan mode that walks every channel once per start pulse.
// Latency: 1 cycle from ctrl/in_bus to out_data. Full throughput when out_ready is held high.
// Backpressure: the output slot holds data, sel and valid while out_valid & !out_ready. A new load happens only when the slot is free.
module mux_sel_scan #(
  parameter int NUM_IN = 64,
  parameter int DATA_W = 1,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         ctrl,
  input  logic [NUM_IN*DATA_W-1:0] in_bus,
  input  logic                     mode,
  input  logic                     start,
  input  logic                     abort,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     scan_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIRECT = 2'd1,
    S_SCAN   = 2'd2
  } state_t;

  // One extra bit so that NUM_IN itself fits when it is a power of two.
  localparam logic [SEL_W:0]   NUM_IN_X = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  idx, idx_nxt;
  logic              last_loaded, last_nxt;   // final scan word is already in the output slot
  logic              done_nxt;
  logic              load;
  logic              flush;
  logic              free;
  logic [SEL_W-1:0]  dir_sel;
  logic [SEL_W-1:0]  load_sel;
  logic [DATA_W-1:0] ch [NUM_IN];

  // Unflatten the input bus into one word per channel.
  for (genvar k = 0; k < NUM_IN; k++) begin : g_ch
    assign ch[k] = in_bus[k*DATA_W +: DATA_W];
  end

  // An out-of-range select falls through to channel 0, the same as the in0 default of the old combinational mux.
  assign dir_sel = ({1'b0, ctrl} < NUM_IN_X) ? ctrl : '0;
  assign free    = !out_valid || out_ready;
  assign busy    = (state != S_IDLE);

  // Next-state logic: choose the load source, step the scan index and raise the done pulse.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    last_nxt  = last_loaded;
    done_nxt  = 1'b0;
    load      = 1'b0;
    flush     = 1'b0;
    load_sel  = dir_sel;
    if (abort) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
      last_nxt  = 1'b0;
      flush     = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (!mode) begin
            state_nxt = S_DIRECT;
          end else if (start) begin
            state_nxt = S_SCAN;
            idx_nxt   = '0;
            last_nxt  = 1'b0;
          end
        end
        S_DIRECT: begin
          if (mode) begin
            state_nxt = S_IDLE;
          end else if (free) begin
            load = 1'b1;
          end
        end
        S_SCAN: begin
          load_sel = idx;
          if (!last_loaded) begin
            if (free) begin
              load = 1'b1;
              if (idx == LAST_IDX) begin
                last_nxt = 1'b1;
                idx_nxt  = '0;
              end else begin
                idx_nxt = idx + SEL_W'(1);
              end
            end
          end else if (out_valid && out_ready) begin
            // The last word has been taken. The done pulse is registered, so no load happens in the done cycle.
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
            last_nxt  = 1'b0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Control state: FSM, scan index, last-word flag and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      last_loaded <= 1'b0;
      scan_done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      last_loaded <= last_nxt;
      scan_done   <= done_nxt;
    end
  end

  // Output slot: a load overwrites it, an accept without a load empties it, and it holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= ch[load_sel];
      out_sel   <= load_sel;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_sel_scan.sv
// Directed bench for mux_sel_scan. Three instances are used: 64x8, 48x8 and 8x8.
// Every channel k carries k ^ 8'hA5.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled at the same point.
module tb_mux_sel_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] ctrl6;
  logic [2:0] ctrl3;
  logic       mode, start, abort, out_ready;

  logic [64*8-1:0] in_bus64;
  logic [48*8-1:0] in_bus48;
  logic [8*8-1:0]  in_bus8;

  logic [7:0] a_data, b_data, c_data;
  logic [5:0] a_sel, b_sel;
  logic [2:0] c_sel;
  logic       a_valid, b_valid, c_valid;
  logic       a_busy, b_busy, c_busy;
  logic       a_done, b_done, c_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_sel_scan #(.NUM_IN(64), .DATA_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl6), .in_bus(in_bus64), .mode(mode), .start(start),
    .abort(abort), .out_data(a_data), .out_sel(a_sel), .out_valid(a_valid),
    .out_ready(out_ready), .busy(a_busy), .scan_done(a_done));

  mux_sel_scan #(.NUM_IN(48), .DATA_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl6), .in_bus(in_bus48), .mode(mode), .start(start),
    .abort(abort), .out_data(b_data), .out_sel(b_sel), .out_valid(b_valid),
    .out_ready(out_ready), .busy(b_busy), .scan_done(b_done));

  mux_sel_scan #(.NUM_IN(8), .DATA_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl3), .in_bus(in_bus8), .mode(mode), .start(start),
    .abort(abort), .out_data(c_data), .out_sel(c_sel), .out_valid(c_valid),
    .out_ready(out_ready), .busy(c_busy), .scan_done(c_done));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    ctrl6 = '0; ctrl3 = '0;
    for (int k = 0; k < 64; k++) in_bus64[k*8 +: 8] = 8'(k) ^ 8'hA5;
    for (int k = 0; k < 48; k++) in_bus48[k*8 +: 8] = 8'(k) ^ 8'hA5;
    for (int k = 0; k < 8; k++)  in_bus8[k*8 +: 8]  = 8'(k) ^ 8'hA5;
    tick(); tick();
    checks++; if (a_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", a_data); end
    checks++; if (a_sel !== 6'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", a_sel); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", a_valid); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", a_done); end
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL reset_c_valid got %b exp 0", c_valid); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
        errors++; $display("FAIL idle_quiet cyc %0d valid %b busy %b exp 0 0", i, a_valid, a_busy);
      end
    end
  endtask

  task automatic test_direct();
    logic [5:0] sels [4];
    logic [7:0] exps [4];
    sels[0] = 6'd0;  exps[0] = 8'hA5;
    sels[1] = 6'd1;  exps[1] = 8'hA4;
    sels[2] = 6'd33; exps[2] = 8'h84;
    sels[3] = 6'd63; exps[3] = 8'h9A;
    mode = 1'b0; out_ready = 1'b1;
    tick();  // IDLE -> DIRECT
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL direct_busy got %b exp 1", a_busy); end
    for (int i = 0; i < 4; i++) begin
      ctrl6 = sels[i];
      tick();
      checks++;
      if (a_data !== exps[i] || a_sel !== sels[i] || a_valid !== 1'b1) begin
        errors++;
        $display("FAIL direct_ctrl%0d got data %h sel %0d valid %b exp %h %0d 1",
                 sels[i], a_data, a_sel, a_valid, exps[i], sels[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    ctrl6 = 6'd50;
    tick();
    checks++;
    if (b_data !== 8'hA5 || b_sel !== 6'd0) begin
      errors++; $display("FAIL oor_ctrl50 got data %h sel %0d exp A5 0", b_data, b_sel);
    end
    ctrl6 = 6'd47;
    tick();
    checks++;
    if (b_data !== 8'h8A || b_sel !== 6'd47) begin
      errors++; $display("FAIL oor_ctrl47 got data %h sel %0d exp 8A 47", b_data, b_sel);
    end
  endtask

  task automatic test_backpressure();
    ctrl6 = 6'd5; out_ready = 1'b1;
    tick();
    checks++; if (a_data !== 8'hA0) begin errors++; $display("FAIL bp_load5 got %h exp A0", a_data); end
    out_ready = 1'b0; ctrl6 = 6'd9;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (a_data !== 8'hA0 || a_sel !== 6'd5 || a_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold cyc %0d got %h %0d %b exp A0 5 1", i, a_data, a_sel, a_valid);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (a_data !== 8'hAC || a_sel !== 6'd9) begin
      errors++; $display("FAIL bp_release got %h %0d exp AC 9", a_data, a_sel);
    end
  endtask

  task automatic test_full_scan();
    logic [2:0] pre_sel;
    logic [7:0] pre_dat;
    logic       pre_v;
    int         exp_idx = 0;
    int         done_cnt = 0;
    bit         finished = 0;
    mode = 1'b1; out_ready = 1'b1;
    tick(); tick();  // DIRECT -> IDLE, drain
    checks++; if (c_busy !== 1'b0 || c_valid !== 1'b0) begin
      errors++; $display("FAIL scan_pre_idle busy %b valid %b exp 0 0", c_busy, c_valid); end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
      out_ready = (cyc % 2 == 0);
      pre_v = c_valid; pre_sel = c_sel; pre_dat = c_data;
      tick();
      if (c_done) done_cnt++;
      if (pre_v && out_ready) begin
        checks++;
        if (int'(pre_sel) !== exp_idx || pre_dat !== ({5'd0, pre_sel} ^ 8'hA5)) begin
          errors++; $display("FAIL scan_accept got sel %0d data %h exp sel %0d", pre_sel, pre_dat, exp_idx);
        end
        exp_idx++;
        if (pre_sel == 3'd7) begin
          finished = 1;
          checks++;
          if (c_done !== 1'b1 || c_busy !== 1'b0 || c_valid !== 1'b0) begin
            errors++; $display("FAIL scan_done_pulse got done %b busy %b valid %b exp 1 0 0", c_done, c_busy, c_valid);
          end
        end
      end else if (pre_v) begin
        checks++;
        if (c_sel !== pre_sel || c_data !== pre_dat || c_valid !== 1'b1) begin
          errors++; $display("FAIL scan_hold got %0d %h exp %0d %h", c_sel, c_data, pre_sel, pre_dat);
        end
      end
    end
    checks++;
    if (!finished || exp_idx != 8) begin
      errors++; $display("FAIL scan_complete got %0d accepted exp 8", exp_idx);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (c_done !== 1'b0 || done_cnt != 1) begin
      errors++; $display("FAIL scan_done_once got now %b count %0d exp 0 1", c_done, done_cnt);
    end
  endtask

  task automatic test_abort_reset();
    mode = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();  // words 0,1,2 loaded; idx = 3
    checks++; if (c_sel !== 3'd2) begin errors++; $display("FAIL abort_pre got sel %0d exp 2", c_sel); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (c_valid !== 1'b0 || c_busy !== 1'b0 || c_done !== 1'b0) begin
      errors++; $display("FAIL abort_clear got valid %b busy %b done %b exp 0 0 0", c_valid, c_busy, c_done);
    end
    start = 1'b1; tick(); start = 1'b0;
    tick();
    checks++;
    if (c_sel !== 3'd0 || c_valid !== 1'b1 || c_data !== 8'hA5) begin
      errors++; $display("FAIL abort_rescan got sel %0d valid %b data %h exp 0 1 A5", c_sel, c_valid, c_data);
    end
    tick(); tick(); tick(); tick();  // words 1..4 loaded; idx = 5
    checks++; if (c_sel !== 3'd4) begin errors++; $display("FAIL rst_pre got sel %0d exp 4", c_sel); end
    rst_n = 1'b0;
    #2;
    checks++;
    if (c_valid !== 1'b0 || c_busy !== 1'b0 || c_sel !== 3'd0 || c_data !== 8'h00) begin
      errors++; $display("FAIL rst_async got valid %b busy %b sel %0d data %h exp 0 0 0 00", c_valid, c_busy, c_sel, c_data);
    end
    #1;
    rst_n = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    checks++;
    if (c_sel !== 3'd0 || c_valid !== 1'b1 || c_data !== 8'hA5) begin
      errors++; $display("FAIL rst_rescan got sel %0d valid %b data %h exp 0 1 A5", c_sel, c_valid, c_data);
    end
    for (int i = 1; i < 8; i++) tick();  // words 1..7
    tick();
    checks++;
    if (c_done !== 1'b1 || c_busy !== 1'b0) begin
      errors++; $display("FAIL rst_rescan_done got done %b busy %b exp 1 0", c_done, c_busy);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_out_of_range();
    test_backpressure();
    test_full_scan();
    test_abort_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
